// File: rtl/fill_word_expander.sv
// Expands compact fill tokens (zero / one / literal / repeat-last, with a repeat count)
// into a stream of full-width words, with valid/ready on both the token and word sides.
module fill_word_expander #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    input  logic [CNT_W-1:0] in_count,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [WIDTH-1:0]   last_word;
    logic [WIDTH-1:0]   prev_word;
    logic [WIDTH-1:0]   new_word;
    logic               final_word;
    logic               out_fire;
    logic               in_fire;

    assign final_word = (state == EXPAND) && (remaining == '0);
    assign out_fire   = out_valid && out_ready;
    assign in_ready   = (state == IDLE) || (final_word && out_ready);
    assign in_fire    = in_valid && in_ready;

    // A word retiring in the same cycle as the accept counts as the last emitted word.
    always_comb begin
        prev_word = out_fire ? out_data : last_word;
        new_word  = prev_word;
        case (in_code)
            2'b00:   new_word = {WIDTH{1'b0}};
            2'b01:   new_word = {WIDTH{1'b1}};
            2'b10:   new_word = in_data;
            default: new_word = prev_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            last_word <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (out_fire) begin
                last_word <= out_data;
            end
            if (in_fire) begin
                state     <= EXPAND;
                remaining <= in_count;
                out_data  <= new_word;
                out_valid <= 1'b1;
                out_last  <= (in_count == '0);
                busy      <= 1'b1;
            end else if (out_fire) begin
                if (remaining != '0) begin
                    remaining <= remaining - CNT_W'(1);
                    out_last  <= (remaining == CNT_W'(1));
                end else begin
                    // Final word retired with no follow-on token: drop back to idle.
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fill_word_expander.sv
// Randomised bench for fill_word_expander: token stream is expanded by a queue-based
// model of the output word stream and compared cycle by cycle against the DUT.
module tb_fill_word_expander;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        logic [1:0]       code;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] data;
    } tok_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_code;
    logic [CNT_W-1:0] in_count;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    fill_word_expander #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_count  (in_count),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      checks;
    int unsigned      failures;
    tok_t             tok_q[$];
    logic [WIDTH:0]   exp_q[$];
    logic             rdy_pat[$];
    logic [WIDTH-1:0] model_last;
    int unsigned      vprob;
    int unsigned      rprob;
    int unsigned      words_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream-level model: a token becomes count+1 copies of its word; repeat uses the
    // final word of the previous token (zero after reset).
    task automatic expand(input tok_t t);
        logic [WIDTH-1:0] w;
        case (t.code)
            2'b00:   w = '0;
            2'b01:   w = '1;
            2'b10:   w = t.data;
            default: w = model_last;
        endcase
        for (int i = 0; i <= int'(t.count); i++) begin
            exp_q.push_back({(i == int'(t.count)), w});
        end
        model_last = w;
    endtask

    task automatic step();
        logic exp_valid;
        @(posedge clk);
        #1;
        in_valid = (tok_q.size() != 0) && ($urandom_range(0, 99) < vprob);
        if (tok_q.size() != 0) begin
            in_code  = tok_q[0].code;
            in_count = tok_q[0].count;
            in_data  = tok_q[0].data;
        end else begin
            in_code  = 2'($urandom);
            in_count = CNT_W'($urandom);
            in_data  = $urandom;
        end
        if (rdy_pat.size() != 0) out_ready = rdy_pat.pop_front();
        else                     out_ready = ($urandom_range(0, 99) < rprob);
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        check("no_x", 64'(^{out_valid, out_data, out_last, busy, in_ready} === 1'bx), 64'd0);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(exp_valid));
        check("in_ready", 64'(in_ready),
              64'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
        if (out_valid && exp_valid) begin
            check("out_data", 64'(out_data), 64'(exp_q[0][WIDTH-1:0]));
            check("out_last", 64'(out_last), 64'(exp_q[0][WIDTH]));
        end
        if (out_valid && out_ready && exp_valid) begin
            void'(exp_q.pop_front());
            words_seen++;
        end
        if (in_valid && in_ready) expand(tok_q.pop_front());
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((tok_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(tok_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic push_tok(input logic [1:0] code, input int unsigned count, input logic [WIDTH-1:0] data);
        tok_t t;
        t.code  = code;
        t.count = CNT_W'(count);
        t.data  = data;
        tok_q.push_back(t);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        int unsigned n;
        int unsigned w0;
        checks = 0; failures = 0; words_seen = 0;
        model_last = '0;
        in_valid = 1'b0; in_code = '0; in_count = '0; in_data = '0; out_ready = 1'b0;
        vprob = 100; rprob = 100;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: four all-one words, one-cycle latency
        push_tok(2'b01, 3, $urandom);
        drain(50);

        // T2: literal then back-to-back repeat, no bubble
        push_tok(2'b10, 0, 32'hDEADBEEF);
        push_tok(2'b11, 1, $urandom);
        drain(50);

        // T3: backpressure on a three-word zero fill
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        push_tok(2'b00, 2, $urandom);
        drain(50);

        // T4: maximum count gives 2^CNT_W words
        w0 = words_seen;
        push_tok(2'b01, 255, $urandom);
        drain(400);
        check("max_count_words", 64'(words_seen - w0), 64'd256);

        // T5: reset while the second word of a literal token is pending
        rdy_pat = '{1'b1, 1'b1, 1'b0};
        push_tok(2'b10, 5, 32'h12345678);
        n = 0;
        while (exp_q.size() != 5 && n < 20) begin
            step();
            n++;
        end
        check("t5_reach_second", 64'(exp_q.size()), 64'd5);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        tok_q.delete();
        model_last = '0;
        #1 rst_n = 1'b1;
        push_tok(2'b11, 0, $urandom);
        drain(50);

        // T6: random tokens and backpressure against the model
        for (int c = 0; c < 10000; c++) begin
            if (tok_q.size() < 2) begin
                push_tok(2'($urandom),
                         ($urandom_range(0, 49) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5),
                         $urandom);
            end
            vprob = $urandom_range(30, 100);
            rprob = $urandom_range(20, 100);
            step();
        end
        vprob = 100; rprob = 100;
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
